// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage. Owns the program counter, presents the word address
// to the instruction memory and captures the returned instruction into the
// IF/ID pipeline register. Handles stalls from the hazard unit, redirects from
// resolved branches/jumps, halt requests and out-of-range fetch detection.
//
// Ports
//   clk              in   1   rising-edge clock
//   rst              in   1   synchronous active-high reset
//   instruction_addr out  10  word address to IMem (pc[11:2])
//   instruction      in   32  IMem read data (combinational from the address)
//   stall            in   1   hold PC, IF/ID and fetch counter
//   redirect_valid   in   1   load PC from redirect_target, squash IF/ID
//   redirect_target  in   32  redirect byte address
//   halt_req         in   1   enter HALTED
//   pc_out           out  32  current PC
//   if_id_pc         out  32  PC of the instruction in IF/ID
//   if_id_instr      out  32  instruction in IF/ID
//   if_id_valid      out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_count      out  32  valid instructions loaded into IF/ID
//   misalign_err     out  1   sticky: a redirect target was not word aligned
//   range_err        out  1   sticky: a fetch was attempted past IMem
//   halted           out  1   stage is in HALTED
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          IM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  instruction_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_err,
  output logic        range_err,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // First byte address past the end of IMem.
  localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS * 4);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;
  logic        r_misalign;
  logic        r_range;
  logic        r_halted;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_instr_nxt;
  logic        w_if_id_valid_nxt;
  logic [31:0] w_fetch_count_nxt;
  logic        w_misalign_nxt;
  logic        w_range_nxt;

  // Next-state and next-IF/ID computation; redirect is checked ahead of the
  // state case because it behaves identically in RUN and HALTED.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;
    w_if_id_valid_nxt = r_if_id_valid;
    w_fetch_count_nxt = r_fetch_count;
    w_misalign_nxt    = r_misalign;
    w_range_nxt       = r_range;

    if (redirect_valid) begin
      w_state_nxt       = ST_RUN;
      w_pc_nxt          = {redirect_target[31:2], 2'b00};
      w_if_id_pc_nxt    = 32'h0000_0000;
      w_if_id_instr_nxt = NOP_INSTR;
      w_if_id_valid_nxt = 1'b0;
      w_misalign_nxt    = r_misalign | (redirect_target[1:0] != 2'b00);
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            w_state_nxt       = ST_HALTED;
            w_if_id_pc_nxt    = 32'h0000_0000;
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
          end else if (stall) begin
            w_state_nxt = ST_RUN;
          end else if (r_pc >= PC_LIMIT) begin
            // Fetch past IMem: flag it and park instead of reading garbage.
            w_state_nxt       = ST_HALTED;
            w_range_nxt       = 1'b1;
            w_if_id_pc_nxt    = 32'h0000_0000;
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
          end else begin
            w_pc_nxt          = r_pc + 32'd4;
            w_if_id_pc_nxt    = r_pc;
            w_if_id_instr_nxt = instruction;
            w_if_id_valid_nxt = 1'b1;
            w_fetch_count_nxt = r_fetch_count + 32'd1;
          end
        end
        ST_HALTED: begin
          w_state_nxt       = ST_HALTED;
          w_if_id_pc_nxt    = 32'h0000_0000;
          w_if_id_instr_nxt = NOP_INSTR;
          w_if_id_valid_nxt = 1'b0;
        end
        default: begin
          // Unreachable encoding: recover to RUN with a bubble.
          w_state_nxt       = ST_RUN;
          w_if_id_pc_nxt    = 32'h0000_0000;
          w_if_id_instr_nxt = NOP_INSTR;
          w_if_id_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, PC, IF/ID and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0000_0000;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
      r_misalign    <= 1'b0;
      r_range       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_misalign    <= w_misalign_nxt;
      r_range       <= w_range_nxt;
      r_halted      <= (w_state_nxt == ST_HALTED);
    end
  end

  assign instruction_addr = r_pc[11:2];
  assign pc_out           = r_pc;
  assign if_id_pc         = r_if_id_pc;
  assign if_id_instr      = r_if_id_instr;
  assign if_id_valid      = r_if_id_valid;
  assign fetch_count      = r_fetch_count;
  assign misalign_err     = r_misalign;
  assign range_err        = r_range;
  assign halted           = r_halted;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Bench for inst_fetch. A driver issues directed then random per-cycle inputs,
// steps a behavioural model of the fetch stage and queues the expected
// post-edge outputs; a monitor pops one expectation after every clock edge and
// compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [9:0]  instruction_addr;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;
  logic        range_err;
  logic        halted;

  inst_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_addr (instruction_addr),
    .instruction      (instruction),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt_req         (halt_req),
    .pc_out           (pc_out),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid),
    .fetch_count      (fetch_count),
    .misalign_err     (misalign_err),
    .range_err        (range_err),
    .halted           (halted)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image, read combinationally by the DUT.
  logic [31:0] mem [0:1023];
  assign instruction = mem[instruction_addr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] count;
    logic        mis;
    logic        rng;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: what the stage should look like after each edge.
  logic [31:0] m_pc, m_ipc, m_instr, m_count;
  logic        m_valid, m_mis, m_rng, m_hlt;

  task automatic m_bubble();
    m_valid = 1'b0;
    m_ipc   = 32'h0;
    m_instr = 32'h0;
  endtask

  // One clock edge of the fetch stage, written from the behavioural rules.
  task automatic m_step(input bit r, input bit s, input bit rv,
                        input logic [31:0] t, input bit h);
    if (r) begin
      m_pc = 32'h0; m_count = 32'h0; m_mis = 1'b0; m_rng = 1'b0; m_hlt = 1'b0;
      m_bubble();
    end else if (rv) begin
      m_pc  = t & 32'hFFFF_FFFC;
      m_mis = m_mis | (t % 4 != 0);
      m_hlt = 1'b0;
      m_bubble();
    end else if (m_hlt) begin
      m_bubble();
    end else if (h) begin
      m_hlt = 1'b1;
      m_bubble();
    end else if (s) begin
      // everything holds
    end else if (m_pc >= 32'd4096) begin
      m_rng = 1'b1;
      m_hlt = 1'b1;
      m_bubble();
    end else begin
      m_ipc   = m_pc;
      m_instr = mem[m_pc / 4];
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, and pass the edge.
  task automatic cyc(input bit r, input bit s, input bit rv,
                     input logic [31:0] t, input bit h);
    exp_t e;
    rst = r; stall = s; redirect_valid = rv; redirect_target = t; halt_req = h;
    m_step(r, s, rv, t, h);
    e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.valid = m_valid;
    e.count = m_count; e.mis = m_mis; e.rng = m_rng; e.hlt = m_hlt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out",       pc_out,                e.pc);
        chk("instr_addr",   {22'h0, instruction_addr}, {22'h0, e.pc[11:2]});
        chk("if_id_pc",     if_id_pc,              e.ipc);
        chk("if_id_instr",  if_id_instr,           e.instr);
        chk("if_id_valid",  {31'h0, if_id_valid},  {31'h0, e.valid});
        chk("fetch_count",  fetch_count,           e.count);
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
        chk("range_err",    {31'h0, range_err},    {31'h0, e.rng});
        chk("halted",       {31'h0, halted},       {31'h0, e.hlt});
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] t;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h100 + 32'(k);
    m_pc = 32'h0; m_count = 32'h0; m_mis = 1'b0; m_rng = 1'b0; m_hlt = 1'b0;
    m_valid = 1'b0; m_ipc = 32'h0; m_instr = 32'h0;

    // Reset, then four straight fetches of words 0..3.
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 0);
    // Back to 0x8, stall three cycles there, then resume.
    cyc(0, 0, 1, 32'h8, 0);
    cyc(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    // Redirect with a simultaneous stall and halt request.
    cyc(0, 1, 1, 32'h40, 1);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    // Misaligned redirect; flag persists over further redirects until reset.
    cyc(0, 0, 1, 32'h43, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'h10, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    // Last legal word, then fetch past the end.
    cyc(0, 0, 1, 32'hFFC, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 0);
    // Halted ignores stall/halt; redirect restarts; reset mid-run.
    cyc(0, 0, 1, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);

    // Random memory contents and random control traffic.
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        6:       t = 32'($urandom_range(0, 4095));
        7:       t = 32'hFF0 + 32'($urandom_range(0, 15));
        8:       t = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
        default: t = $urandom;
      endcase
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0),
          t,
          ($urandom_range(0, 29) == 0));
    end

    cyc(0, 0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
